program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning instruction-memory depth is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first loaded word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  stream byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port load_req  input  1  restart-load request.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  32  byte address of the word being written.
REQ-011 SHALL have port imem_wdata  output  32  instruction word being written.
REQ-012 SHALL have port cpu_reset  output  1  holds the processor core in reset.
REQ-013 SHALL have port done  output  1  load completed, checksum good.
REQ-014 SHALL have port error  output  1  load aborted.
REQ-015 SHALL have port words_loaded  output  16  count of words written in the current load.

Function
REQ-016 SHALL transfer a byte only on a rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL accept the stream format: 2-byte big-endian word count N, then 4*N instruction bytes, then 1 checksum byte.
REQ-018 SHALL implement states HDR0, HDR1, DATA, CSUM, DONE, ERR, with in_ready = 1 only in HDR0, HDR1, DATA and CSUM.
REQ-019 SHALL transition HDR0->HDR1 on a transfer, and HDR1->DATA on a transfer if N>0.
REQ-020 SHALL transition HDR1->CSUM on a transfer if N==0.
REQ-021 SHALL transition HDR1->ERR if N > 2^ADDR_WIDTH.
REQ-022 SHALL assemble instruction bytes big-endian: the first byte of each group of four becomes wdata[31:24].
REQ-023 SHALL, one cycle after the fourth byte of word k is accepted, pulse imem_we for exactly one cycle, with imem_addr = BASE_ADDR + 4*k and imem_wdata = the assembled word.
REQ-024 SHALL increment words_loaded in the same cycle as each imem_we pulse.
REQ-025 SHALL transition DATA->CSUM when the fourth byte of word N-1 is accepted.
REQ-026 SHALL compute the checksum as the 8-bit XOR of all header bytes and instruction bytes.
REQ-027 SHALL, on the CSUM transfer, go to DONE if the received byte equals the computed XOR, otherwise go to ERR.
REQ-028 SHALL hold cpu_reset = 1 in every state except DONE.
REQ-029 SHALL make done = 1 and cpu_reset = 0 starting the cycle after a good checksum byte is accepted.
REQ-030 SHALL hold error = 1 in ERR only.
REQ-031 SHALL keep imem_we = 0 in HDR0, HDR1, CSUM, DONE and ERR, except for the final-word pulse issued in the cycle after the last data byte is accepted.
REQ-032 SHALL, on load_req = 1 in DONE or ERR, go to HDR0 next cycle: cpu_reset = 1, done = 0, error = 0, words_loaded, checksum and byte index cleared.
REQ-033 SHALL ignore load_req in HDR0, HDR1, DATA and CSUM.
REQ-034 SHALL preserve all partial-word state while in_valid = 0 (stalls of any length allowed).

Reset
REQ-035 SHALL on reset enter HDR0 with in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0, checksum=0.
REQ-036 SHALL abort any partial load on reset mid-operation and issue no further imem_we pulses for that load.

Structure
REQ-037 SHALL take the state enum, header length (2), and checksum width (8) from the shared package mips_pkg.
REQ-038 SHALL place byte-to-word packing (byte index counter, shift register, word-complete flag) in a sub-module named byte_packer.

Verification
REQ-039 SHALL check: stream 00 01 20 08 00 05 2C -> one imem_we with addr 0x0, wdata 0x20080005; then done=1, cpu_reset=0.
REQ-040 SHALL check: N=3 with in_valid toggled every other cycle -> three writes at 0x0, 0x4, 0x8 with correct words; words_loaded=3.
REQ-041 SHALL check: N=1 with a checksum byte off by one -> error=1, cpu_reset stays 1, done=0.
REQ-042 SHALL check: header 01 01 (N=257, ADDR_WIDTH=8) -> ERR after the second byte, no imem_we pulses.
REQ-043 SHALL check: stream 00 00 00 -> no writes, done=1.
REQ-044 SHALL check: reset asserted after 6 data bytes, then load_req and a valid N=1 stream -> only the new word is written, at 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared loader definitions: state encoding and stream framing constants.
package mips_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} ld_state_e;
  localparam int HDR_LEN = 2;
  localparam int CSUM_W  = 8;
endpackage

// File: rtl/program_loader_packer.sv
// Collects instruction bytes big-endian into 32-bit words.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);
  logic [1:0]  idx_q;
  logic [23:0] shreg_q;

  // Word completes combinationally with its fourth byte so the top can register it.
  assign word_done_o = push_i && (idx_q == 2'd3);
  assign word_o      = {shreg_q, byte_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (clr_i) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (push_i) begin
      idx_q   <= idx_q + 2'd1;
      shreg_q <= {shreg_q[15:0], byte_i};
    end
  end
endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checked program image into instruction memory.
module program_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);
  localparam int CW = HDR_LEN * 8;
  localparam logic [CW:0] MAX_WORDS = (CW+1)'(1) << ADDR_WIDTH;

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [15:0]       words_q, words_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic              xfer, restart, word_done;
  logic [31:0]       word;
  logic [CW-1:0]     n_full;

  assign in_ready = (state_q == HDR0) || (state_q == HDR1) ||
                    (state_q == DATA) || (state_q == CSUM);
  assign xfer     = in_valid && in_ready;
  assign n_full   = {cnt_q[CW-1:8], in_data};

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (restart),
    .push_i      (xfer && (state_q == DATA)),
    .byte_i      (in_data),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    restart = 1'b0;
    case (state_q)
      HDR0: if (xfer) begin
        cnt_d   = {in_data, 8'h00};
        csum_d  = csum_q ^ in_data;
        state_d = HDR1;
      end
      HDR1: if (xfer) begin
        cnt_d  = n_full;
        csum_d = csum_q ^ in_data;
        if ({1'b0, n_full} > MAX_WORDS) state_d = ERR;
        else if (n_full == '0)          state_d = CSUM;
        else                            state_d = DATA;
      end
      DATA: if (xfer) begin
        csum_d = csum_q ^ in_data;
        if (word_done) begin
          // Address uses the pre-increment count: word k lands at BASE + 4k.
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + {14'b0, words_q, 2'b00};
          wdata_d = word;
          words_d = words_q + 16'd1;
          if (words_q == cnt_q - 16'd1) state_d = CSUM;
        end
      end
      CSUM: if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
      DONE, ERR: if (load_req) begin
        state_d = HDR0;
        cnt_d   = '0;
        csum_d  = '0;
        words_d = '0;
        restart = 1'b1;
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR0;
      cnt_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign cpu_reset    = (state_q != DONE);
  assign words_loaded = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed streams against a stream-level model of the expected writes and outcome.
module tb_program_loader;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, load_req;
  logic        imem_we, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_req(load_req), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  typedef struct {logic [31:0] a; logic [31:0] d; logic [15:0] wl;} wr_t;
  wr_t         exp_q[$];
  wr_t         ecur;
  int          total = 0, bad = 0, nwr = 0;
  logic [31:0] last_a = '0, last_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Every cycle out of reset: status coherence and each write against the model queue.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_vs_status", 32'(in_ready), 32'(!(done || error)));
      if (imem_we) begin
        if (exp_q.size() == 0) chk("spurious_we", 32'(1), 32'(0));
        else begin
          ecur = exp_q.pop_front();
          chk("wr_addr", imem_addr, ecur.a);
          chk("wr_data", imem_wdata, ecur.d);
          chk("wr_count", 32'(words_loaded), 32'(ecur.wl));
        end
        nwr++;
        last_a = imem_addr;
        last_d = imem_wdata;
      end
    end
  end

  // outc: 0 incomplete, 1 good load, 2 error
  task automatic model_stream(input logic [7:0] b[$], input int sent,
                              output int outc, output int nw);
    logic [7:0] cs;
    int n, lim;
    cs = '0; outc = 0; nw = 0;
    if (sent < 2) return;
    n = int'({b[0], b[1]});
    if (n > (1 << AW)) begin outc = 2; return; end
    for (int k = 0; k < n; k++)
      if (2 + 4*k + 3 < sent) begin
        exp_q.push_back('{32'(4*k), {b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]}, 16'(k+1)});
        nw = k + 1;
      end
    lim = (sent < 2 + 4*n) ? sent : 2 + 4*n;
    for (int i = 0; i < lim; i++) cs ^= b[i];
    if (sent >= 3 + 4*n) outc = (b[2+4*n] == cs) ? 1 : 2;
  endtask

  task automatic send(input logic [7:0] b[$], input int cnt, input bit gap);
    int g;
    for (int i = 0; i < cnt; i++) begin
      g = 0;
      in_data = b[i]; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && g < 50) begin g++; @(negedge clk); end
      if (!in_ready) begin
        chk("ready_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input string nm, input logic [7:0] b[$], input bit gap);
    int outc, nw;
    model_stream(b, b.size(), outc, nw);
    send(b, b.size(), gap);
    repeat (3) @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'(outc == 1));
    chk({nm, "_error"}, 32'(error), 32'(outc == 2));
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(outc != 1));
    chk({nm, "_words"}, 32'(words_loaded), 32'(nw));
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    chk("rst_cpu_reset", 32'(cpu_reset), 32'(1));
    chk("rst_words", 32'(words_loaded), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(in_ready), 32'(1));
    chk({nm, "_we"}, 32'(imem_we), 32'(0));
    chk({nm, "_addr"}, imem_addr, 32'(0));
    chk({nm, "_wdata"}, imem_wdata, 32'(0));
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(1));
    chk({nm, "_done"}, 32'(done), 32'(0));
    chk({nm, "_error"}, 32'(error), 32'(0));
    chk({nm, "_words"}, 32'(words_loaded), 32'(0));
  endtask

  initial begin
    logic [7:0] s[$];
    int base, outc, nw;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; load_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // single word, good checksum
    base = nwr;
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_stream("one_word", s, 1'b0);
    chk("one_word_nwr", 32'(nwr - base), 32'(1));
    chk("one_word_addr_lit", last_a, 32'h0);
    chk("one_word_data_lit", last_d, 32'h2008_0005);
    chk("one_word_done_lit", 32'(done), 32'(1));

    // three words, valid toggling
    restart();
    base = nwr;
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
          8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
    run_stream("three_gap", s, 1'b1);
    chk("three_nwr", 32'(nwr - base), 32'(3));
    chk("three_addr_lit", last_a, 32'h8);
    chk("three_data_lit", last_d, 32'h99AA_BBCC);
    chk("three_words_lit", 32'(words_loaded), 32'(3));

    // checksum off by one
    restart();
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    run_stream("bad_csum", s, 1'b0);
    chk("bad_csum_error_lit", 32'(error), 32'(1));

    // oversize header: error right after second byte
    restart();
    base = nwr;
    s = '{8'h01, 8'h01};
    model_stream(s, 2, outc, nw);
    send(s, 2, 1'b0);
    @(negedge clk);
    chk("oversize_error", 32'(error), 32'(outc == 2));
    chk("oversize_ready", 32'(in_ready), 32'(0));
    repeat (3) @(negedge clk);
    chk("oversize_nwr", 32'(nwr - base), 32'(0));
    @(posedge clk); #1;

    // empty program
    restart();
    base = nwr;
    s = '{8'h00, 8'h00, 8'h00};
    run_stream("empty", s, 1'b0);
    chk("empty_nwr", 32'(nwr - base), 32'(0));

    // reset mid-load after six data bytes, then a fresh single-word load
    restart();
    base = nwr;
    s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    model_stream(s, 8, outc, nw);
    send(s, 8, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    chk("midrst_pending", 32'(exp_q.size()), 32'(0));
    chk("midrst_nwr", 32'(nwr - base), 32'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    chk("ignored_req_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    base = nwr;
    s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
    run_stream("after_rst", s, 1'b0);
    chk("after_rst_nwr", 32'(nwr - base), 32'(1));
    chk("after_rst_addr_lit", last_a, 32'h0);
    chk("after_rst_data_lit", last_d, 32'hCAFE_BABE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
